// File: rtl/fifo_frame_reader_if.sv
// rtl/fifo_frame_reader_if.sv - FIFO read port and output stream bundle for fifo_frame_reader
interface fifo_frame_reader_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int LEVEL_WIDTH = 15
);
  // FIFO read side
  logic                   fifo_rd_en;
  logic [DATA_WIDTH-1:0]  fifo_rd_data;
  logic                   fifo_rd_empty;
  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level;
  // Framed output stream
  logic [DATA_WIDTH-1:0]  m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic                   m_sop;
  logic                   m_eop;

  // Reader side: drives the FIFO read enable and the output stream
  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_rd_empty,
    input  fifo_rd_water_level,
    output m_data,
    output m_valid,
    input  m_ready,
    output m_sop,
    output m_eop
  );

  // Environment side: the FIFO plus the downstream consumer
  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_rd_empty,
    output fifo_rd_water_level,
    input  m_data,
    input  m_valid,
    output m_ready,
    input  m_sop,
    input  m_eop
  );
endinterface

// File: rtl/fifo_frame_reader.sv
// rtl/fifo_frame_reader.sv - drains whole frames from the read side of a FIFO into a framed stream
module fifo_frame_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int LEVEL_WIDTH = 15,
  parameter int FRAME_LEN   = 1024
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic                enable,
  fifo_frame_reader_if.master bus,
  output logic                busy,
  output logic [15:0]         frame_cnt
);

  // Counters share the level width: FRAME_LEN <= 2^(LEVEL_WIDTH-1) always fits.
  localparam int CW = LEVEL_WIDTH;
  localparam logic [CW-1:0] FLEN = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, WAIT_LEVEL, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         rd_issued_q, rd_issued_d;
  logic [CW-1:0]         out_idx_q, out_idx_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] buf0_q, buf1_q;   // buf0_q is the head entry
  logic [1:0]            count_q;
  logic [15:0]           frame_cnt_q;

  logic                  rd_en;
  logic                  pop;
  logic                  push;
  logic                  last_pop;
  logic [2:0]            occ;

  assign pop      = (count_q != 2'd0) & bus.m_ready;
  assign push     = inflight_q;
  assign last_pop = pop & (out_idx_q == LAST);
  // Slots committed after this cycle's pop; a new read is only issued if
  // its data (arriving next cycle) is guaranteed a free entry.
  assign occ      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en    = (state_q == READ) & (rd_issued_q < FLEN) &
                    !bus.fifo_rd_empty & (occ < 3'd2);

  // State, counters and in-flight flag
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q     <= IDLE;
      rd_issued_q <= '0;
      out_idx_q   <= '0;
      inflight_q  <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      rd_issued_q <= rd_issued_d;
      out_idx_q   <= out_idx_d;
      inflight_q  <= rd_en;
      if (last_pop) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  // Next-state and counter updates; enable only matters outside a frame
  always_comb begin
    state_d     = state_q;
    rd_issued_d = rd_issued_q;
    out_idx_d   = out_idx_q;
    if (rd_en) begin
      rd_issued_d = rd_issued_q + CW'(1);
    end
    if (pop) begin
      out_idx_d = last_pop ? '0 : out_idx_q + CW'(1);
    end
    case (state_q)
      IDLE: begin
        if (enable) state_d = WAIT_LEVEL;
      end
      WAIT_LEVEL: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (bus.fifo_rd_water_level >= FLEN) begin
          state_d = READ;
        end
      end
      READ: begin
        if (rd_en && (rd_issued_q == LAST)) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_pop) begin
          state_d     = enable ? WAIT_LEVEL : IDLE;
          rd_issued_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Two-entry output buffer fed by the read data one cycle after each read
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      buf0_q  <= '0;
      buf1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) buf0_q <= bus.fifo_rd_data;
          else                 buf1_q <= bus.fifo_rd_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          buf0_q  <= buf1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            buf0_q <= bus.fifo_rd_data;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= bus.fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (count_q != 2'd0);
  assign bus.m_data     = buf0_q;
  assign bus.m_sop      = bus.m_valid & (out_idx_q == '0);
  assign bus.m_eop      = bus.m_valid & (out_idx_q == LAST);
  assign busy           = (state_q == READ) | (state_q == DRAIN);
  assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb/tb_fifo_frame_reader.sv - directed self-checking bench for fifo_frame_reader
module tb_fifo_frame_reader;
  localparam int DW  = 16;
  localparam int LW  = 15;
  localparam int FL  = 1024;
  localparam int FLS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        enable, enable_s;
  logic        busy, busy_s;
  logic [15:0] frame_cnt, frame_cnt_s;

  fifo_frame_reader_if #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW)) bus ();
  fifo_frame_reader_if #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW)) bus_s ();

  fifo_frame_reader #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .FRAME_LEN(FL)) dut (
    .rd_clk(clk), .rd_rst(rst), .enable(enable), .bus(bus.master),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  fifo_frame_reader #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .FRAME_LEN(FLS)) dut_s (
    .rd_clk(clk), .rd_rst(rst), .enable(enable_s), .bus(bus_s.master),
    .busy(busy_s), .frame_cnt(frame_cnt_s)
  );

  // FIFO model for the main instance: each sample's value is its write index.
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic stall_en = 1'b0;
  int   stall_ptr = 0;
  assign bus.fifo_rd_empty       = (rd_ptr == wr_ptr) || (stall_en && (rd_ptr == stall_ptr));
  assign bus.fifo_rd_water_level = LW'(wr_ptr - rd_ptr);
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_rd_data <= DW'(rd_ptr);
      rd_ptr           <= rd_ptr + 1;
    end
  end

  // Always-full FIFO model for the short-frame instance
  int s_ptr = 0;
  assign bus_s.fifo_rd_empty       = 1'b0;
  assign bus_s.fifo_rd_water_level = LW'(100);
  assign bus_s.m_ready             = 1'b1;
  always @(posedge clk) begin
    if (bus_s.fifo_rd_en) begin
      bus_s.fifo_rd_data <= DW'(s_ptr);
      s_ptr              <= s_ptr + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  int              cyc = 0;
  int              outstanding = 0;
  int              bp_viol = 0;
  int              hold_viol = 0;
  int              rd_en_cnt = 0;
  logic            prev_stall = 1'b0;
  logic [DW-1:0]   prev_data = '0;
  logic [DW+1:0]   beats[$];
  int              beat_cyc[$];

  // One clock of stimulus plus passive recording of accepted beats
  task automatic cycle(input logic rdy);
    logic pop;
    @(negedge clk);
    bus.m_ready = rdy;
    #1;
    cyc++;
    if (prev_stall && (!bus.m_valid || (bus.m_data !== prev_data))) hold_viol++;
    pop = bus.m_valid & rdy;
    if (bus.fifo_rd_en && ((outstanding - int'(pop)) >= 2)) bp_viol++;
    if (bus.fifo_rd_en) rd_en_cnt++;
    if (pop) begin
      beats.push_back({bus.m_eop, bus.m_sop, bus.m_data});
      beat_cyc.push_back(cyc);
    end
    outstanding = outstanding + int'(bus.fifo_rd_en) - int'(pop);
    prev_stall  = bus.m_valid & !rdy;
    prev_data   = bus.m_data;
  endtask

  task automatic test_reset();
    logic [38:0] outs;
    rst = 1'b1; enable = 1'b0; enable_s = 1'b0; bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    outs = {bus.fifo_rd_en, bus.m_valid, bus.m_sop, bus.m_eop, busy, frame_cnt, bus.m_data};
    n_checks++;
    if (outs !== 39'd0) begin $display("FAIL reset_outputs got %h want 0", outs); n_fail++; end
    n_checks++;
    if ({busy_s, frame_cnt_s, bus_s.m_valid} !== 18'd0) begin
      $display("FAIL reset_small got %h want 0", {busy_s, frame_cnt_s, bus_s.m_valid}); n_fail++;
    end
    rst = 1'b0;
  endtask

  task automatic test_level_and_frame();
    int k0, bad, first, guard;
    enable = 1'b1;
    wr_ptr = wr_ptr + (FL - 1);
    repeat (5) cycle(1'b1);
    n_checks++;
    if ({bus.fifo_rd_en, busy} !== 2'b00) begin
      $display("FAIL level_1023_idle got rd_en/busy=%b want 00", {bus.fifo_rd_en, busy}); n_fail++;
    end
    beats.delete(); beat_cyc.delete();
    wr_ptr = wr_ptr + 1;
    k0 = cyc;
    cycle(1'b1);
    n_checks++;
    if ({bus.fifo_rd_en, busy} !== 2'b11) begin
      $display("FAIL first_rd_en got rd_en/busy=%b want 11", {bus.fifo_rd_en, busy}); n_fail++;
    end
    guard = 0;
    while (beats.size() < FL && guard < 1200) begin cycle(1'b1); guard++; end
    n_checks++;
    if (beats.size() !== FL) begin $display("FAIL frame1_count got %0d want %0d", beats.size(), FL); n_fail++; end
    else begin
      n_checks++;
      if (beat_cyc[0] !== k0 + 3) begin $display("FAIL first_beat_latency got %0d want %0d", beat_cyc[0] - k0, 3); n_fail++; end
      n_checks++;
      if (beat_cyc[FL-1] - beat_cyc[0] !== FL - 1) begin
        $display("FAIL frame1_contiguous got span %0d want %0d", beat_cyc[FL-1] - beat_cyc[0], FL - 1); n_fail++;
      end
    end
    bad = 0; first = 0;
    foreach (beats[i]) if (beats[i] !== {(i == FL-1), (i == 0), DW'(i)}) begin if (bad == 0) first = i; bad++; end
    n_checks++;
    if (bad !== 0) begin $display("FAIL frame1_beats got %0d bad (first %0d = %h) want 0", bad, first, beats[first]); n_fail++; end
    cycle(1'b1);
    n_checks++;
    if (frame_cnt !== 16'd1) begin $display("FAIL frame1_cnt got %0d want 1", frame_cnt); n_fail++; end
  endtask

  task automatic test_backpressure();
    int base, bad, first, guard;
    base = rd_ptr;
    bp_viol = 0; hold_viol = 0;
    beats.delete(); beat_cyc.delete();
    wr_ptr = wr_ptr + FL;
    guard = 0;
    while (beats.size() < FL && guard < 6000) begin cycle(1'($urandom_range(0, 1))); guard++; end
    n_checks++;
    if (beats.size() !== FL) begin $display("FAIL bp_count got %0d want %0d", beats.size(), FL); n_fail++; end
    bad = 0; first = 0;
    foreach (beats[i]) if (beats[i] !== {(i == FL-1), (i == 0), DW'(base + i)}) begin if (bad == 0) first = i; bad++; end
    n_checks++;
    if (bad !== 0) begin $display("FAIL bp_beats got %0d bad (first %0d = %h) want 0", bad, first, beats[first]); n_fail++; end
    n_checks++;
    if (bp_viol !== 0) begin $display("FAIL bp_overissue got %0d reads with 2 slots committed want 0", bp_viol); n_fail++; end
    n_checks++;
    if (hold_viol !== 0) begin $display("FAIL bp_hold got %0d unstable stalled beats want 0", hold_viol); n_fail++; end
    cycle(1'b1);
    n_checks++;
    if (frame_cnt !== 16'd2) begin $display("FAIL bp_cnt got %0d want 2", frame_cnt); n_fail++; end
  endtask

  task automatic test_underrun();
    int base, bad, first, guard, rd0;
    base = rd_ptr;
    stall_ptr = base + 500; stall_en = 1'b1;
    beats.delete(); beat_cyc.delete();
    wr_ptr = wr_ptr + FL;
    guard = 0;
    while (beats.size() < 500 && guard < 700) begin cycle(1'b1); guard++; end
    rd0 = rd_en_cnt;
    repeat (10) cycle(1'b1);
    n_checks++;
    if ({bus.m_valid, rd_en_cnt - rd0, beats.size()} !== {1'b0, 0, 500}) begin
      $display("FAIL underrun_stall got valid=%b reads=%0d beats=%0d want 0/0/500", bus.m_valid, rd_en_cnt - rd0, beats.size()); n_fail++;
    end
    stall_en = 1'b0;
    guard = 0;
    while (beats.size() < FL && guard < 1200) begin cycle(1'b1); guard++; end
    n_checks++;
    if (beats.size() !== FL) begin $display("FAIL underrun_count got %0d want %0d", beats.size(), FL); n_fail++; end
    bad = 0; first = 0;
    foreach (beats[i]) if (beats[i] !== {(i == FL-1), (i == 0), DW'(base + i)}) begin if (bad == 0) first = i; bad++; end
    n_checks++;
    if (bad !== 0) begin $display("FAIL underrun_beats got %0d bad (first %0d = %h) want 0", bad, first, beats[first]); n_fail++; end
  endtask

  task automatic test_enable_drop();
    int base, bad, first, guard, rd0;
    base = rd_ptr;
    beats.delete(); beat_cyc.delete();
    wr_ptr = wr_ptr + FL;
    guard = 0;
    while (beats.size() < FL && guard < 1200) begin
      cycle(1'b1);
      if (beats.size() == 300) enable = 1'b0;
      guard++;
    end
    bad = 0; first = 0;
    foreach (beats[i]) if (beats[i] !== {(i == FL-1), (i == 0), DW'(base + i)}) begin if (bad == 0) first = i; bad++; end
    n_checks++;
    if ({beats.size(), bad} !== {FL, 0}) begin
      $display("FAIL endrop_frame got %0d beats, %0d bad want %0d, 0", beats.size(), bad, FL); n_fail++;
    end
    cycle(1'b1);
    wr_ptr = wr_ptr + FL;
    rd0 = rd_en_cnt;
    repeat (20) cycle(1'b1);
    n_checks++;
    if ({rd_en_cnt - rd0, busy, bus.m_valid} !== {0, 1'b0, 1'b0}) begin
      $display("FAIL endrop_idle got reads=%0d busy=%b valid=%b want 0/0/0", rd_en_cnt - rd0, busy, bus.m_valid); n_fail++;
    end
    n_checks++;
    if (frame_cnt !== 16'd4) begin $display("FAIL endrop_cnt got %0d want 4", frame_cnt); n_fail++; end
  endtask

  task automatic test_reset_mid_frame();
    int base, bad, first, guard;
    logic [38:0] outs;
    beats.delete(); beat_cyc.delete();
    enable = 1'b1;
    guard = 0;
    while (beats.size() < 300 && guard < 400) begin cycle(1'b1); guard++; end
    rst = 1'b1;
    #1;
    outs = {bus.fifo_rd_en, bus.m_valid, bus.m_sop, bus.m_eop, busy, frame_cnt, bus.m_data};
    n_checks++;
    if (outs !== 39'd0) begin $display("FAIL midreset_outputs got %h want 0", outs); n_fail++; end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    outstanding = 0; prev_stall = 1'b0;
    base = rd_ptr;
    wr_ptr = wr_ptr + FL;
    beats.delete(); beat_cyc.delete();
    guard = 0;
    while (beats.size() < FL && guard < 1200) begin cycle(1'b1); guard++; end
    n_checks++;
    if ((beats.size() == 0) || (beats[0] !== {1'b0, 1'b1, DW'(base)})) begin
      $display("FAIL midreset_first_sop got %h want %h", (beats.size() == 0) ? '0 : beats[0], {1'b0, 1'b1, DW'(base)}); n_fail++;
    end
    bad = 0; first = 0;
    foreach (beats[i]) if (beats[i] !== {(i == FL-1), (i == 0), DW'(base + i)}) begin if (bad == 0) first = i; bad++; end
    n_checks++;
    if ({beats.size(), bad} !== {FL, 0}) begin
      $display("FAIL midreset_frame got %0d beats, %0d bad want %0d, 0", beats.size(), bad, FL); n_fail++;
    end
    cycle(1'b1);
    n_checks++;
    if (frame_cnt !== 16'd1) begin $display("FAIL midreset_cnt got %0d want 1", frame_cnt); n_fail++; end
    enable = 1'b0;
  endtask

  task automatic test_frame_cnt_wrap();
    int idx, bad, guard, base;
    logic pend;
    logic [15:0] caps[$];
    @(negedge clk);
    force dut_s.frame_cnt_q = 16'hfffe;
    @(negedge clk);
    release dut_s.frame_cnt_q;
    #1;
    n_checks++;
    if (frame_cnt_s !== 16'hfffe) begin $display("FAIL wrap_preload got %h want fffe", frame_cnt_s); n_fail++; end
    base = s_ptr;
    enable_s = 1'b1;
    idx = 0; bad = 0; guard = 0; pend = 1'b0;
    while (caps.size() < 3 && guard < 200) begin
      @(negedge clk);
      #1;
      if (pend) caps.push_back(frame_cnt_s);
      pend = bus_s.m_valid & bus_s.m_eop;
      if (bus_s.m_valid) begin
        if ({bus_s.m_eop, bus_s.m_sop, bus_s.m_data} !== {((idx % FLS) == FLS-1), ((idx % FLS) == 0), DW'(base + idx)}) bad++;
        idx++;
      end
      guard++;
    end
    enable_s = 1'b0;
    n_checks++;
    if ({idx, bad} !== {3 * FLS, 0}) begin $display("FAIL wrap_beats got %0d beats, %0d bad want %0d, 0", idx, bad, 3 * FLS); n_fail++; end
    n_checks++;
    if ((caps.size() < 1) || (caps[0] !== 16'hffff)) begin $display("FAIL wrap_cnt_ffff got %h want ffff", (caps.size() < 1) ? 16'hx : caps[0]); n_fail++; end
    n_checks++;
    if ((caps.size() < 2) || (caps[1] !== 16'h0000)) begin $display("FAIL wrap_cnt_0000 got %h want 0000", (caps.size() < 2) ? 16'hx : caps[1]); n_fail++; end
    n_checks++;
    if ((caps.size() < 3) || (caps[2] !== 16'h0001)) begin $display("FAIL wrap_cnt_0001 got %h want 0001", (caps.size() < 3) ? 16'hx : caps[2]); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_level_and_frame();
    test_backpressure();
    test_underrun();
    test_enable_drop();
    test_reset_mid_frame();
    test_frame_cnt_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
